// File: rtl/axi_burst_master.sv
// axi_burst_master: AXI4 master that runs one INCR write or read burst per
// local command, with at most one transaction outstanding.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd_*               command handshake: direction, start address, len (beats-1)
//   wr_*                write data stream, passed straight to the W channel
//   rd_*                read data stream, passed straight from the R channel
//   done, done_resp     one-cycle completion pulse and worst response seen
//   m_axi_*             AXI4 master AW/W/B/AR/R channels (lock/cache/prot tied
//                       off outside this block)
module axi_burst_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH   = 12,
    parameter int unsigned AXI_ID     = 0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,

    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,

    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    input  logic                  rd_ready,

    output logic                  done,
    output logic [1:0]            done_resp,

    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,

    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam logic [ID_WIDTH-1:0] ID_C    = ID_WIDTH'(AXI_ID);
    localparam logic [2:0]          SIZE_C  = 3'($clog2(STRB_WIDTH));
    localparam logic [1:0]          INCR_C  = 2'b01;
    localparam logic [1:0]          SLVERR  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              count_q, count_d;
    logic [1:0]              acc_q, acc_d;
    logic                    done_q, done_d;
    logic [1:0]              done_resp_q, done_resp_d;

    logic                    r_err;
    logic [1:0]              r_beat_resp;
    logic [1:0]              b_resp;

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Constant / latched AXI address-channel fields.
    assign m_axi_awid    = ID_C;
    assign m_axi_arid    = ID_C;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_awsize  = SIZE_C;
    assign m_axi_arsize  = SIZE_C;
    assign m_axi_awburst = INCR_C;
    assign m_axi_arburst = INCR_C;

    // Data paths are pure pass-through; only the valids/readies are gated by state.
    assign m_axi_wdata   = wr_data;
    assign m_axi_wstrb   = {STRB_WIDTH{1'b1}};
    assign rd_data       = m_axi_rdata;
    assign rd_last       = m_axi_rlast;

    assign done          = done_q;
    assign done_resp     = done_resp_q;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            done_q      <= 1'b0;
            done_resp_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            done_q      <= done_d;
            done_resp_q <= done_resp_d;
        end
    end

    // Next-state, handshake decode and response accumulation.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        count_d       = count_q;
        acc_d         = acc_q;
        done_d        = 1'b0;
        done_resp_d   = done_resp_q;

        cmd_ready     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        wr_ready      = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        rd_valid      = 1'b0;

        b_resp        = resp_max(m_axi_bresp, (m_axi_bid != ID_C) ? SLVERR : 2'b00);

        // Beat error: wrong ID, or rlast not lining up with the requested length.
        r_err         = (m_axi_rid != ID_C) ||
                        (m_axi_rlast ? (count_q != len_q) : (count_q == len_q));
        r_beat_resp   = resp_max(resp_max(acc_q, m_axi_rresp), r_err ? SLVERR : 2'b00);

        case (state_q)
            S_IDLE: begin
                // Hold off for the done cycle so a new command starts after it.
                cmd_ready = !done_q;
                if (cmd_valid && !done_q) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    count_d = '0;
                    acc_d   = '0;
                    state_d = cmd_write ? S_AW : S_AR;
                end
            end
            S_AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                m_axi_wvalid = wr_valid;
                wr_ready     = m_axi_wready;
                m_axi_wlast  = (count_q == len_q);
                if (wr_valid && m_axi_wready) begin
                    if (count_q == len_q) begin
                        state_d = S_B;
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            S_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    done_d      = 1'b1;
                    done_resp_d = b_resp;
                    state_d     = S_IDLE;
                end
            end
            S_AR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                rd_valid     = m_axi_rvalid;
                m_axi_rready = rd_ready;
                if (m_axi_rvalid && rd_ready) begin
                    acc_d = r_beat_resp;
                    // Saturate so an overrunning slave cannot wrap back onto len.
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                    if (m_axi_rlast) begin
                        done_d      = 1'b1;
                        done_resp_d = r_beat_resp;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: directed commands against a small AXI SRAM
// slave model, with queued expectations checked by a negedge monitor.
module tb_axi_burst_master;

    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 16;
    localparam int unsigned SW     = DW / 8;
    localparam int unsigned IW     = 12;
    localparam int unsigned AXI_ID = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [DW-1:0] wr_data;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_last, rd_ready;
    logic          done;
    logic [1:0]    done_resp;

    logic [IW-1:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]    m_axi_awlen, m_axi_arlen;
    logic [2:0]    m_axi_awsize, m_axi_arsize;
    logic [1:0]    m_axi_awburst, m_axi_arburst;
    logic          m_axi_awvalid, m_axi_awready;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata;
    logic [SW-1:0] m_axi_wstrb;
    logic          m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]    m_axi_bresp, m_axi_rresp;
    logic          m_axi_bvalid, m_axi_bready;
    logic          m_axi_arvalid, m_axi_arready;
    logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;

    axi_burst_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW), .AXI_ID(AXI_ID)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .done(done), .done_resp(done_resp),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // ---------------- AXI SRAM slave model ----------------
    logic [DW-1:0] mem [0:16383];
    int            aw_delay, ar_delay;
    logic          w_rand;
    logic [1:0]    force_bresp;
    logic [IW-1:0] slave_rid;
    int            aw_cnt, ar_cnt;
    logic [AW-1:0] s_waddr, s_raddr;
    logic [7:0]    s_wlen, s_wbeat, s_rlen, s_rbeat;
    logic          s_wready, b_pending, r_active;
    int            r_idx;

    assign r_idx         = int'(s_raddr[15:2]) + int'(s_rbeat);
    assign m_axi_awready = (aw_cnt >= aw_delay);
    assign m_axi_arready = (ar_cnt >= ar_delay);
    assign m_axi_wready  = s_wready;
    assign m_axi_bvalid  = b_pending;
    assign m_axi_bresp   = force_bresp;
    assign m_axi_bid     = IW'(AXI_ID);
    assign m_axi_rvalid  = r_active;
    assign m_axi_rdata   = mem[r_idx];
    assign m_axi_rlast   = r_active && (s_rbeat == s_rlen);
    assign m_axi_rid     = slave_rid;
    assign m_axi_rresp   = 2'b00;

    always @(posedge clk) begin
        if (rst) begin
            aw_cnt    <= 0;
            ar_cnt    <= 0;
            s_wbeat   <= '0;
            s_wready  <= 1'b1;
            b_pending <= 1'b0;
            r_active  <= 1'b0;
            s_rbeat   <= '0;
        end else begin
            s_wready <= w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_cnt  <= 0;
                s_waddr <= m_axi_awaddr;
                s_wlen  <= m_axi_awlen;
                s_wbeat <= '0;
            end else if (m_axi_awvalid) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                mem[int'(s_waddr[15:2]) + int'(s_wbeat)] <= m_axi_wdata;
                s_wbeat <= s_wbeat + 8'd1;
                if (s_wbeat == s_wlen) b_pending <= 1'b1;
            end
            if (m_axi_bvalid && m_axi_bready) b_pending <= 1'b0;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_cnt   <= 0;
                s_raddr  <= m_axi_araddr;
                s_rlen   <= m_axi_arlen;
                s_rbeat  <= '0;
                r_active <= 1'b1;
            end else if (m_axi_arvalid) begin
                ar_cnt <= ar_cnt + 1;
            end
            if (m_axi_rvalid && m_axi_rready) begin
                if (s_rbeat == s_rlen) r_active <= 1'b0;
                else                   s_rbeat  <= s_rbeat + 8'd1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; } cmd_t;

    beat_t      exp_w[$], exp_r[$];
    cmd_t       exp_aw[$], exp_ar[$];
    logic [1:0] exp_resp[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: DUT presented an event with no expectation queued (t=%0t)", name, $time);
    endtask

    logic          aw_wait, ar_wait;
    logic [AW-1:0] aw_wait_addr, ar_wait_addr;
    logic [7:0]    aw_wait_len;

    // Monitor: pops the matching expectation whenever the DUT shows a handshake.
    always @(negedge clk) begin
        beat_t b;
        cmd_t  c;
        if (rst) begin
            aw_wait = 1'b0;
            ar_wait = 1'b0;
        end else begin
            if (aw_wait) begin
                check("aw_hold_valid", 64'(m_axi_awvalid), 64'd1);
                check("aw_hold_addr", 64'({m_axi_awaddr, m_axi_awlen}), 64'({aw_wait_addr, aw_wait_len}));
            end
            if (ar_wait) begin
                check("ar_hold_valid", 64'(m_axi_arvalid), 64'd1);
                check("ar_hold_addr", 64'(m_axi_araddr), 64'(ar_wait_addr));
            end
            aw_wait      = m_axi_awvalid && !m_axi_awready;
            aw_wait_addr = m_axi_awaddr;
            aw_wait_len  = m_axi_awlen;
            ar_wait      = m_axi_arvalid && !m_axi_arready;
            ar_wait_addr = m_axi_araddr;

            if (m_axi_awvalid && m_axi_awready) begin
                if (exp_aw.size() == 0) unexpected("aw");
                else begin
                    c = exp_aw.pop_front();
                    check("awaddr", 64'(m_axi_awaddr), 64'(c.addr));
                    check("awlen", 64'(m_axi_awlen), 64'(c.len));
                    check("awburst_size_id", 64'({m_axi_awburst, m_axi_awsize, m_axi_awid}),
                          64'({2'b01, 3'd2, 12'd0}));
                end
            end
            if (m_axi_arvalid && m_axi_arready) begin
                if (exp_ar.size() == 0) unexpected("ar");
                else begin
                    c = exp_ar.pop_front();
                    check("araddr", 64'(m_axi_araddr), 64'(c.addr));
                    check("arlen", 64'(m_axi_arlen), 64'(c.len));
                    check("arburst_size_id", 64'({m_axi_arburst, m_axi_arsize, m_axi_arid}),
                          64'({2'b01, 3'd2, 12'd0}));
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (exp_w.size() == 0) unexpected("wbeat");
                else begin
                    b = exp_w.pop_front();
                    check("wdata", 64'(m_axi_wdata), 64'(b.data));
                    check("wlast", 64'(m_axi_wlast), 64'(b.last));
                    check("wstrb", 64'(m_axi_wstrb), 64'h0F);
                end
            end
            if (rd_valid && rd_ready) begin
                if (exp_r.size() == 0) unexpected("rbeat");
                else begin
                    b = exp_r.pop_front();
                    check("rd_data", 64'(rd_data), 64'(b.data));
                    check("rd_last", 64'(rd_last), 64'(b.last));
                end
            end
            if (done) begin
                if (exp_resp.size() == 0) unexpected("done");
                else check("done_resp", 64'(done_resp), 64'(exp_resp.pop_front()));
            end
        end
    end

    // rd_ready: always high, or a coin flip each cycle when rd_rand is set.
    logic rd_rand;
    initial begin
        rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rd_ready = rd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [7:0] len,
                            output int t0);
        int n;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!cmd_ready) unexpected("cmd_ready_timeout");
        t0 = cyc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int t0, input int exp_lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 400) begin
            n++;
            @(negedge clk);
        end
        if (!done) unexpected("done_timeout");
        else if (exp_lat > 0) check("write_latency", 64'(cyc - t0), 64'(exp_lat));
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [DW-1:0] base, input logic [DW-1:0] step,
                            input int gaps, input logic [1:0] resp, input int exp_lat);
        int t0, n;
        exp_aw.push_back('{addr: addr, len: len});
        for (int i = 0; i <= int'(len); i++)
            exp_w.push_back('{data: base + step * DW'(i), last: (i == int'(len))});
        exp_resp.push_back(resp);
        send_cmd(1'b1, addr, len, t0);
        for (int i = 0; i <= int'(len); i++) begin
            if (gaps != 0) repeat (i % 3) begin @(posedge clk); #1; end
            wr_valid = 1'b1;
            wr_data  = base + step * DW'(i);
            n = 0;
            @(negedge clk);
            while (!wr_ready && n < 100) begin
                n++;
                @(negedge clk);
            end
            if (!wr_ready) unexpected("wr_ready_timeout");
            @(posedge clk);
            #1;
            wr_valid = 1'b0;
        end
        wait_done(t0, exp_lat);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [DW-1:0] base, input logic [DW-1:0] step,
                           input logic [1:0] resp);
        int t0;
        exp_ar.push_back('{addr: addr, len: len});
        for (int i = 0; i <= int'(len); i++)
            exp_r.push_back('{data: base + step * DW'(i), last: (i == int'(len))});
        exp_resp.push_back(resp);
        send_cmd(1'b0, addr, len, t0);
        wait_done(t0, 0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valids"},
              64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
                   wr_ready, rd_valid}), 64'd0);
        check({tag, "_done"}, 64'({done, done_resp}), 64'd0);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0;
        rd_rand = 1'b0; w_rand = 1'b0; aw_delay = 0; ar_delay = 0;
        force_bresp = 2'b00; slave_rid = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_quiet("reset");

        // Basic burst write then read-back.
        do_write(16'h0100, 8'd3, 32'h11, 32'h11, 0, 2'b00, 0);
        do_read (16'h0100, 8'd3, 32'h11, 32'h11, 2'b00);

        // Single beat at the top of a 4 KB page; zero-wait latency is 4.
        do_write(16'h0FFC, 8'd0, 32'hDEADBEEF, 32'h0, 0, 2'b00, 4);
        do_read (16'h0FFC, 8'd0, 32'hDEADBEEF, 32'h0, 2'b00);

        // Backpressure on every channel.
        aw_delay = 3; ar_delay = 3; w_rand = 1'b1; rd_rand = 1'b1;
        do_write(16'h0200, 8'd7, 32'hC0DE0000, 32'h101, 1, 2'b00, 0);
        do_read (16'h0200, 8'd7, 32'hC0DE0000, 32'h101, 2'b00);
        aw_delay = 0; ar_delay = 0; w_rand = 1'b0; rd_rand = 1'b0;

        // Error responses: SLVERR on B, then a wrong RID on R.
        force_bresp = 2'b10;
        do_write(16'h0300, 8'd1, 32'h55, 32'h11, 0, 2'b10, 0);
        force_bresp = 2'b00;
        slave_rid = 12'h001;
        do_read (16'h0300, 8'd1, 32'h55, 32'h11, 2'b10);
        slave_rid = '0;

        // Reset in the middle of a len=7 write: only beat 0 reaches the bus.
        exp_aw.push_back('{addr: 16'h0400, len: 8'd7});
        exp_w.push_back('{data: 32'hA0, last: 1'b0});
        send_cmd(1'b1, 16'h0400, 8'd7, n);
        wr_valid = 1'b1;
        wr_data  = 32'hA0;
        n = 0;
        @(negedge clk);
        while (!wr_ready && n < 100) begin n++; @(negedge clk); end
        @(posedge clk);
        #1;
        wr_data = 32'hA1;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        check_quiet("midreset");
        repeat (5) @(negedge clk);

        // Normal traffic after the abandoned burst.
        do_write(16'h0500, 8'd1, 32'h12345678, 32'h1, 0, 2'b00, 0);
        do_read (16'h0500, 8'd1, 32'h12345678, 32'h1, 2'b00);

        repeat (5) @(negedge clk);
        check("leftover_expectations",
              64'(exp_aw.size() + exp_ar.size() + exp_w.size() + exp_r.size() + exp_resp.size()),
              64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1);
    end

endmodule
